// File: rtl/priority_decoder.sv
// Per-lane priority extractor for the write arbiter: registers each lane's priority
// field and freezes the granted lane's value from grant until its end-of-packet.
module priority_decoder #(
    parameter int arbiter_data_width = 256,
    parameter int num_of_ports       = 16,
    parameter int priority_width     = 3,
    parameter int priority_offset    = 4,
    parameter int select_width       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [arbiter_data_width*num_of_ports-1:0] priority_decoder_in,
    input  logic [num_of_ports-1:0]                    ready,
    input  logic [num_of_ports-1:0]                    eop,
    input  logic [select_width-1:0]                    select,
    output logic [num_of_ports*priority_width-1:0]     priority_out
);

    logic [num_of_ports-1:0][priority_width-1:0] prio_q, prio_d;
    logic [num_of_ports-1:0]                     lock_q, lock_d;

    // Only the priority fields are consumed; the rest of each lane word is don't-care.
    logic unused_data;
    assign unused_data = ^priority_decoder_in;

    always_comb begin
        prio_d = prio_q;
        lock_d = lock_q;
        for (int i = 0; i < num_of_ports; i++) begin
            if (lock_q[i]) begin
                // A locked lane ignores everything but its own eop, and the eop edge does not resample.
                if (eop[i]) begin
                    lock_d[i] = 1'b0;
                end
            end else if (ready[i]) begin
                prio_d[i] = priority_decoder_in[i*arbiter_data_width + priority_offset +: priority_width];
                if (select == select_width'(i)) begin
                    lock_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
            lock_q <= '0;
        end else begin
            prio_q <= prio_d;
            lock_q <= lock_d;
        end
    end

    assign priority_out = prio_q;

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: directed vector table for the grant/eop
// corner cases followed by randomized traffic checked against a lane-level model.
module tb_priority_decoder;

   localparam int DW = 256;
   localparam int NP = 16;
   localparam int PW = 3;
   localparam int PO = 4;
   localparam int SW = 4;

   logic              clk;
   logic              rst;
   logic [DW*NP-1:0]  din;
   logic [NP-1:0]     ready;
   logic [NP-1:0]     eop;
   logic [SW-1:0]     sel;
   logic [NP*PW-1:0]  prio_out;

   int errors;
   int checks;

   // Reference state: one priority value and one lock flag per lane, as plain ints/bits.
   int prio_m [NP];
   bit lock_m [NP];

   typedef struct {
      logic        rst;
      logic [15:0] ready;
      logic [15:0] eop;
      int          sel;
      int          shift;
      int          ovLane;
      int          ovVal;
      int          chkLane;
      int          chkVal;
      string       name;
   } vec_t;

   vec_t vecs [16];

   priority_decoder #(
      .arbiter_data_width(DW),
      .num_of_ports(NP),
      .priority_width(PW),
      .priority_offset(PO),
      .select_width(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .priority_decoder_in(din),
      .ready(ready),
      .eop(eop),
      .select(sel),
      .priority_out(prio_out)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [15:0] rd, input logic [15:0] ep,
                               input int s, input int sh, input int ol, input int ov,
                               input int cl, input int cv, input string nm);
      vec_t v;
      v.rst = r; v.ready = rd; v.eop = ep; v.sel = s; v.shift = sh;
      v.ovLane = ol; v.ovVal = ov; v.chkLane = cl; v.chkVal = cv; v.name = nm;
      return v;
   endfunction

   // Random background data with lane i's priority field set to (i+shift)%8,
   // optionally overridden on one lane.
   function automatic logic [DW*NP-1:0] buildData(input int shift, input int ovLane, input int ovVal);
      logic [DW*NP-1:0] d;
      for (int k = 0; k < DW*NP/32; k++) d[k*32 +: 32] = $urandom;
      for (int i = 0; i < NP; i++) d[i*DW + PO +: PW] = PW'((i + shift) % 8);
      if (ovLane >= 0) d[ovLane*DW + PO +: PW] = PW'(ovVal);
      return d;
   endfunction

   // Lane-level reference behaviour applied for one clock edge.
   task automatic modelStep(input logic r, input logic [NP-1:0] rd, input logic [NP-1:0] ep,
                            input logic [SW-1:0] s, input logic [DW*NP-1:0] d);
      for (int i = 0; i < NP; i++) begin
         if (r) begin
            prio_m[i] = 0;
            lock_m[i] = 1'b0;
         end else if (lock_m[i]) begin
            if (ep[i]) lock_m[i] = 1'b0;
         end else if (rd[i]) begin
            prio_m[i] = int'(d[i*DW + PO +: PW]);
            if (int'(s) == i) lock_m[i] = 1'b1;
         end
      end
   endtask

   function automatic logic [NP*PW-1:0] modelOut();
      logic [NP*PW-1:0] e;
      e = '0;
      for (int i = 0; i < NP; i++) e[i*PW +: PW] = PW'(prio_m[i]);
      return e;
   endfunction

   // Drive one set of inputs across a rising edge, advance the model, settle 1 unit past the edge.
   task automatic applyStimulus(input logic r, input logic [NP-1:0] rd, input logic [NP-1:0] ep,
                                input logic [SW-1:0] s, input logic [DW*NP-1:0] d);
      rst   = r;
      ready = rd;
      eop   = ep;
      sel   = s;
      din   = d;
      @(posedge clk);
      modelStep(r, rd, ep, s, d);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [NP*PW-1:0] actual,
                              input logic [NP*PW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < NP; i++) begin
         prio_m[i] = 0;
         lock_m[i] = 1'b0;
      end
      rst = 1'b1; ready = '0; eop = '0; sel = '0; din = '0;

      // Directed table: rst, ready, eop, select, field shift, override lane/value, checked lane/value
      vecs[0]  = mk(1'b1, 16'hFFFF, 16'h0000,  7, 0, -1, 0,  7, 0, "reset");
      vecs[1]  = mk(1'b0, 16'h0000, 16'h0000,  0, 5, -1, 0,  5, 0, "idle_after_reset");
      vecs[2]  = mk(1'b0, 16'hFFFF, 16'h0000, 15, 0, 15, 7, 15, 7, "free_capture");
      vecs[3]  = mk(1'b0, 16'hFFFF, 16'h0000,  7, 0,  7, 5,  7, 5, "grant_capture");
      vecs[4]  = mk(1'b0, 16'hFFFF, 16'h0000,  7, 3,  7, 2,  7, 5, "locked_hold");
      vecs[5]  = mk(1'b0, 16'hFFFF, 16'h0080,  7, 3,  7, 2,  7, 5, "eop_edge_hold");
      vecs[6]  = mk(1'b0, 16'hFFFF, 16'h0000,  7, 3,  7, 2,  7, 2, "relock_capture");
      vecs[7]  = mk(1'b0, 16'hFFFF, 16'h0000,  7, 3,  7, 4,  7, 2, "relocked_hold");
      vecs[8]  = mk(1'b0, 16'hFFFF, 16'h0008,  9, 3,  3, 6,  3, 6, "eop_unlocked_lane");
      vecs[9]  = mk(1'b1, 16'hFFFF, 16'h0000,  7, 1,  7, 3,  7, 0, "reset_mid_packet");
      vecs[10] = mk(1'b0, 16'hFFFF, 16'h0000,  7, 0,  7, 1,  7, 1, "post_reset_lock");
      vecs[11] = mk(1'b0, 16'hFFFF, 16'h0000,  7, 0,  7, 6,  7, 1, "post_reset_hold");
      vecs[12] = mk(1'b0, 16'hFFFF, 16'h0000, 12, 0,  7, 3,  7, 1, "select_moved_hold");
      vecs[13] = mk(1'b0, 16'hFFFF, 16'h0080, 12, 0,  7, 3,  7, 1, "eop_edge_hold2");
      vecs[14] = mk(1'b0, 16'hFFFF, 16'h0000, 12, 0,  7, 3,  7, 3, "resample_no_grant");
      vecs[15] = mk(1'b0, 16'h0000, 16'h0000, 12, 0,  7, 5,  7, 3, "not_ready_hold");

      for (int v = 0; v < 16; v++) begin
         logic [NP*PW-1:0] laneExp;
         applyStimulus(vecs[v].rst, vecs[v].ready, vecs[v].eop, SW'(vecs[v].sel),
                       buildData(vecs[v].shift, vecs[v].ovLane, vecs[v].ovVal));
         laneExp = '0;
         laneExp[PW-1:0] = PW'(vecs[v].chkVal);
         checkOutput(vecs[v].name, {{(NP-1)*PW{1'b0}}, prio_out[vecs[v].chkLane*PW +: PW]}, laneExp);
         checkOutput({vecs[v].name, "_all"}, prio_out, modelOut());
      end

      // Randomized traffic: sparse eop and reset, random grants and data
      for (int c = 0; c < 400; c++) begin
         logic [NP-1:0] rd;
         logic [NP-1:0] ep;
         rd = NP'($urandom);
         ep = NP'($urandom) & NP'($urandom);
         applyStimulus(($urandom_range(0, 49) == 0), rd, ep, SW'($urandom_range(0, NP-1)),
                       buildData($urandom_range(0, 7), -1, 0));
         checkOutput("random", prio_out, modelOut());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/priority_decoder.md
Name: priority_decoder

Overview:
- Per-port priority extractor for the write arbiter.
- Each of num_of_ports input lanes carries an arbiter_data_width-bit data word with a priority field at bits [priority_offset +: priority_width].
- The block registers each lane's priority and presents all of them on a packed output vector.
- The lane currently granted by the arbiter (select) has its priority frozen from grant until its end-of-packet.

Parameters:
arbiter_data_width, 256, width of one lane's data word
num_of_ports, 16, number of input lanes
priority_width, 3, width of the priority field per lane
priority_offset, 4, LSB position of the priority field inside a lane word
select_width, 4, width of select; must equal clog2(num_of_ports)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
priority_decoder_in  input  arbiter_data_width*num_of_ports  packed lane data; lane i occupies bits [(i+1)*arbiter_data_width-1 : i*arbiter_data_width]
ready  input  num_of_ports  ready[i]=1: lane i holds a valid word to sample
eop  input  num_of_ports  eop[i]=1: end of the packet on lane i (single-cycle pulse)
select  input  select_width  index of the lane currently granted by the arbiter
priority_out  output  num_of_ports*priority_width  packed registered priorities; lane i at bits [(i+1)*priority_width-1 : i*priority_width]

Behaviour:
- All state is updated on the rising edge of clk. The design is purely synchronous; there is no combinational path from inputs to priority_out.
- Per-lane state:
  - prio_reg[i] (priority_width bits), driven directly onto the lane-i slice of priority_out.
  - lock[i] (1 bit).
- Reset (rst=1 at a clock edge): all prio_reg = 0, all lock = 0, so priority_out = 0. Reset overrides all other inputs, including mid-packet; a locked lane unlocks.
- Per lane i, each non-reset edge, evaluated in priority order:
  1. lock[i]=1 and eop[i]=1: lock[i] <= 0; prio_reg[i] holds.
  2. lock[i]=1 and eop[i]=0: prio_reg[i] holds, regardless of ready, select or input data.
  3. lock[i]=0 and ready[i]=1: prio_reg[i] <= lane_i_data[priority_offset +: priority_width]. If select==i on this edge, lock[i] <= 1, so the captured value is the frozen one.
  4. lock[i]=0 and ready[i]=0: prio_reg[i] holds.
- Latency: one clock from a sampled input word to priority_out.
- eop[i] on an unlocked lane has no effect; case 3 or 4 applies.
- The eop edge itself does not resample. Sampling resumes on the following edge. If select still equals i and ready[i]=1 at that edge, the lane relocks with the then-current field value.
- Lanes are fully independent. At most one lane can newly lock per cycle, because select addresses one lane. Multiple lanes may be locked concurrently: a lane stays locked until its own eop even after select moves away.
- select values >= num_of_ports match no lane.
- Only the priority field of each lane word is used. All other data bits are ignored.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> priority_out==0 on the next cycle. Deassert rst with ready=0 -> priority_out stays 0.
- Free-running capture: ready=all 1s, lane i field = i%8, select=15, lane 15 field=7 -> one cycle later lane i of priority_out == i%8.
- Lock on grant: ready=all 1s, select=7, lane-7 field=5, capture edge -> change lane-7 field to 2 and other lanes' fields to new values -> lane 7 stays 5; other lanes update to their new values after one cycle.
- Release on eop: while lane 7 is locked at 5 with field now 2, pulse eop[7] for one cycle -> output still 5 on the eop edge. Next edge with select=7 -> lane 7 becomes 2 and relocks.
- eop on unlocked lane: pulse eop[3] while lane 3 is unlocked and ready[3]=1, field=6 -> lane 3 updates to 6 normally with no side effect.
- Reset mid-packet: lane 7 locked at 5, assert rst -> priority_out==0 and lock[7] clear. After reset with select=7, field=1 -> lane 7 captures 1 and locks.
